// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the MIPS III memory-access stage:
//   - mem_state_e   : bus sequencer states (IDLE -> REQ -> DONE)
//   - is_misaligned : alignment check for half/word accesses
//   - byte_enable   : DBe lane selection for byte/half/word accesses
//   - store_replicate / load_extend : store lane replication, load lane
//                     extraction with sign/zero extension
// ----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam int WORD_ADDR_W = 30;

  // Halfwords need A[0]=0, words need A[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] off, input logic half,
                                         input logic byt);
    return (half & off[0]) | (~half & ~byt & (off != 2'b00));
  endfunction

  // Physical byte lane (0 = bits 7:0) holding address offset 'off'.
  function automatic logic [1:0] byte_lane(input logic [1:0] off, input logic big);
    return big ? (2'd3 - off) : off;
  endfunction

  // Physical half lane (0 = bits 15:0) holding the halfword at off[1].
  function automatic logic half_lane(input logic off1, input logic big);
    return big ? ~off1 : off1;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] off, input logic half,
                                             input logic byt, input logic big);
    logic [3:0] be;
    if (byt)       be = 4'b0001 << byte_lane(off, big);
    else if (half) be = half_lane(off[1], big) ? 4'b1100 : 4'b0011;
    else           be = 4'b1111;
    return be;
  endfunction

  // Replicate narrow store data across lanes so DBe alone selects the target.
  function automatic logic [31:0] store_replicate(input logic [31:0] d, input logic half,
                                                  input logic byt);
    logic [31:0] r;
    if (byt)       r = {4{d[7:0]}};
    else if (half) r = {2{d[15:0]}};
    else           r = d;
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rd, input logic [1:0] off,
                                              input logic half, input logic byt,
                                              input logic sext, input logic big);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{byte_lane(off, big), 3'b000} +: 8];
    h = rd[{half_lane(off[1], big), 4'b0000} +: 16];
    if (byt)       r = {{24{sext & b[7]}}, b};
    else if (half) r = {{16{sext & h[15]}}, h};
    else           r = rd;
    return r;
  endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// ----------------------------------------------------------------------------
// mem_align
// Combinational data formatting for the memory-access stage.
//   addr_lo_i : address offset A[1:0]
//   half_i, byt_i, sext_i : access size and load extension mode
//   wdata_i   : raw store data (rt)        -> wdata_o : lane-replicated data
//   rdata_i   : raw word read from memory  -> rdata_o : extracted/extended load
//   be_o      : byte enables for the access
// ----------------------------------------------------------------------------
module mem_align
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  addr_lo_i,
  input  logic        half_i,
  input  logic        byt_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  assign be_o    = byte_enable(addr_lo_i, half_i, byt_i, BIG_ENDIAN);
  assign wdata_o = store_replicate(wdata_i, half_i, byt_i);
  assign rdata_o = load_extend(rdata_i, addr_lo_i, half_i, byt_i, sext_i, BIG_ENDIAN);

endmodule

// File: rtl/mem_access_stage.sv
// ----------------------------------------------------------------------------
// mem_access_stage
// MEM stage: sequences a registered request/ready data-bus transaction,
// formats loads/stores, tracks the LL/SC link and drives the MEM/WB register.
// Ports:
//   CLK, RST (async, active low)
//   EX/MEM in : MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC,
//               RegWrite, MemtoReg, ALUResult[31:0], ReadData2[31:0], RegDstOut[4:0]
//   Flush, LLClear : kill current instruction / clear link bit
//   Stall, AddrErr : MEM stall (comb), misaligned access flag (comb)
//   Bus out    : DReq, DWe, DAddr[29:0], DBe[3:0], DWData[31:0] (registered)
//   Bus in     : DReady, DRData[31:0]
//   MEM/WB out : W_RegWrite, W_RegDst[4:0], W_WriteData[31:0]
// ----------------------------------------------------------------------------
module mem_access_stage
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemHalf,
  input  logic        MemByte,
  input  logic        MemSignExtend,
  input  logic        LLSC,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  input  logic [4:0]  RegDstOut,
  input  logic        Flush,
  input  logic        LLClear,
  output logic        Stall,
  output logic        AddrErr,
  output logic        DReq,
  output logic        DWe,
  output logic [29:0] DAddr,
  output logic [3:0]  DBe,
  output logic [31:0] DWData,
  input  logic        DReady,
  input  logic [31:0] DRData,
  output logic        W_RegWrite,
  output logic [4:0]  W_RegDst,
  output logic [31:0] W_WriteData
);

  mem_state_e              state_q;
  logic                    dreq_q, dwe_q;
  logic [WORD_ADDR_W-1:0]  daddr_q;
  logic [3:0]              dbe_q;
  logic [31:0]             dwdata_q;
  logic [31:0]             rdata_q;
  logic                    sc_ok_q;
  logic                    abort_q;
  logic                    ll_bit_q, ll_bit_d;
  logic [WORD_ADDR_W-1:0]  ll_addr_q, ll_addr_d;
  logic                    w_regwrite_q, w_regwrite_d;
  logic [4:0]              w_regdst_q;
  logic [31:0]             w_wdata_q, w_wdata_d;

  logic        mem_op, misaligned, is_sc, is_ll, sc_ok, bus_op, retire, sc_success;
  logic [3:0]  be_w;
  logic [31:0] wdata_w, load_w;

  mem_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .addr_lo_i (ALUResult[1:0]),
    .half_i    (MemHalf),
    .byt_i     (MemByte),
    .sext_i    (MemSignExtend),
    .wdata_i   (ReadData2),
    .rdata_i   (rdata_q),
    .be_o      (be_w),
    .wdata_o   (wdata_w),
    .rdata_o   (load_w)
  );

  assign mem_op     = MemRead | MemWrite;
  assign misaligned = mem_op & is_misaligned(ALUResult[1:0], MemHalf, MemByte);
  assign is_sc      = LLSC & MemWrite;
  assign is_ll      = LLSC & MemRead;
  assign sc_ok      = ll_bit_q & (ll_addr_q == ALUResult[31:2]);
  assign bus_op     = mem_op & ~misaligned & ~(is_sc & ~sc_ok) & ~Flush;

  assign Stall   = ((state_q == ST_IDLE) & bus_op) | (state_q == ST_REQ);
  assign AddrErr = misaligned;

  // An instruction retires (and may touch the link) either in IDLE when it
  // needs no bus cycle, or in DONE when its transaction was not aborted.
  assign retire = ((state_q == ST_IDLE) & ~bus_op & ~Flush & ~misaligned) |
                  ((state_q == ST_DONE) & ~abort_q & ~Flush);

  // SC outcome is frozen at request launch so a link change while the
  // store is in flight cannot alter the value returned to rt.
  assign sc_success = (state_q == ST_DONE) ? sc_ok_q : sc_ok;

  always_comb begin
    ll_bit_d  = ll_bit_q;
    ll_addr_d = ll_addr_q;
    if (retire) begin
      if (is_ll) begin
        ll_bit_d  = 1'b1;
        ll_addr_d = ALUResult[31:2];
      end else if (is_sc) begin
        ll_bit_d = 1'b0;
      end else if (MemWrite && (ALUResult[31:2] == ll_addr_q)) begin
        ll_bit_d = 1'b0;
      end
    end
    // LLClear wins over a same-cycle LL completion.
    if (LLClear) ll_bit_d = 1'b0;
  end

  always_comb begin
    w_regwrite_d = RegWrite & ~Stall & ~Flush & ~misaligned & ~abort_q;
    if (MemtoReg)   w_wdata_d = load_w;
    else if (is_sc) w_wdata_d = {31'b0, sc_success};
    else            w_wdata_d = ALUResult;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      dreq_q       <= 1'b0;
      dwe_q        <= 1'b0;
      daddr_q      <= '0;
      dbe_q        <= '0;
      dwdata_q     <= '0;
      rdata_q      <= '0;
      sc_ok_q      <= 1'b0;
      abort_q      <= 1'b0;
      ll_bit_q     <= 1'b0;
      ll_addr_q    <= '0;
      w_regwrite_q <= 1'b0;
      w_regdst_q   <= '0;
      w_wdata_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_op) begin
            dreq_q   <= 1'b1;
            dwe_q    <= MemWrite;
            daddr_q  <= ALUResult[31:2];
            dbe_q    <= be_w;
            dwdata_q <= wdata_w;
            sc_ok_q  <= sc_ok;
            abort_q  <= 1'b0;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Flush cannot cancel an issued request; it only kills the result.
          if (Flush) abort_q <= 1'b1;
          if (DReady) begin
            rdata_q <= DRData;
            dreq_q  <= 1'b0;
            dwe_q   <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          abort_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      ll_bit_q     <= ll_bit_d;
      ll_addr_q    <= ll_addr_d;
      w_regwrite_q <= w_regwrite_d;
      w_regdst_q   <= RegDstOut;
      w_wdata_q    <= w_wdata_d;
    end
  end

  assign DReq        = dreq_q;
  assign DWe         = dwe_q;
  assign DAddr       = daddr_q;
  assign DBe         = dbe_q;
  assign DWData      = dwdata_q;
  assign W_RegWrite  = w_regwrite_q;
  assign W_RegDst    = w_regdst_q;
  assign W_WriteData = w_wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        MemRead = 0, MemWrite = 0, MemHalf = 0, MemByte = 0, MemSignExtend = 0;
  logic        LLSC = 0, RegWrite = 0, MemtoReg = 0;
  logic [31:0] ALUResult = '0, ReadData2 = '0;
  logic [4:0]  RegDstOut = '0;
  logic        Flush = 0, LLClear = 0;
  logic        Stall, AddrErr, DReq, DWe;
  logic [29:0] DAddr;
  logic [3:0]  DBe;
  logic [31:0] DWData;
  logic        DReady = 0;
  logic [31:0] DRData = '0;
  logic        W_RegWrite;
  logic [4:0]  W_RegDst;
  logic [31:0] W_WriteData;

  int total = 0;
  int bad   = 0;

  // Results of the most recent transaction.
  int          r_stalls;
  logic        r_req, r_aerr, r_we;
  logic [29:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;

  always #5 CLK = ~CLK;

  mem_access_stage #(.BIG_ENDIAN(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemHalf(MemHalf), .MemByte(MemByte),
    .MemSignExtend(MemSignExtend), .LLSC(LLSC), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUResult(ALUResult), .ReadData2(ReadData2), .RegDstOut(RegDstOut),
    .Flush(Flush), .LLClear(LLClear), .Stall(Stall), .AddrErr(AddrErr),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DBe(DBe), .DWData(DWData),
    .DReady(DReady), .DRData(DRData),
    .W_RegWrite(W_RegWrite), .W_RegDst(W_RegDst), .W_WriteData(W_WriteData)
  );

  task automatic nop_inputs();
    MemRead = 0; MemWrite = 0; MemHalf = 0; MemByte = 0; MemSignExtend = 0;
    LLSC = 0; RegWrite = 0; MemtoReg = 0; ALUResult = '0; ReadData2 = '0;
    RegDstOut = '0; Flush = 0; LLClear = 0; DReady = 0;
  endtask

  // Presents one instruction (called at posedge+1), acts as the memory with
  // 'waits' wait states, and returns at posedge+1 after the retire edge.
  task automatic issue(input string name, input logic rd, input logic wr, input logic half,
                       input logic byt, input logic sext, input logic llsc, input logic rw,
                       input logic m2r, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] dst, input int waits, input logic [31:0] rdata,
                       input logic flush_req);
    int wc;
    bit flushed, done;
    MemRead = rd; MemWrite = wr; MemHalf = half; MemByte = byt; MemSignExtend = sext;
    LLSC = llsc; RegWrite = rw; MemtoReg = m2r; ALUResult = addr; ReadData2 = wdata;
    RegDstOut = dst;
    r_stalls = 0; r_req = 0; r_aerr = 0; r_we = 0; r_addr = '0; r_be = '0; r_wdata = '0;
    wc = 0; flushed = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (AddrErr) r_aerr = 1;
      if (!Stall) done = 1;
      else begin
        r_stalls++;
        if (DReq) begin
          if (!r_req) begin
            r_req = 1; r_addr = DAddr; r_be = DBe; r_we = DWe; r_wdata = DWData;
          end
          if (flush_req && !flushed) begin Flush = 1; flushed = 1; end
          if (wc == waits) begin DReady = 1; DRData = rdata; end
          else wc++;
        end
        @(posedge CLK); #1;
        DReady = 0; Flush = 0;
      end
    end
    total++;
    if (!done) begin bad++; $display("FAIL %s_timeout: Stall still 1 after 60 cycles, required 0", name); end
    @(posedge CLK); #1;
    $display("txn %s: A=%h stalls=%0d req=%0d DAddr=%h DBe=%b W_RegWrite=%0d W_WriteData=%h",
             name, addr, r_stalls, r_req, r_addr, r_be, W_RegWrite, W_WriteData);
    nop_inputs();
  endtask

  task automatic test_reset();
    nop_inputs();
    RST = 0;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (DReq !== 1'b0) begin bad++; $display("FAIL rst_dreq: got %b want 0", DReq); end
    total++; if (DAddr !== 30'h0) begin bad++; $display("FAIL rst_daddr: got %h want 0", DAddr); end
    total++; if (DBe !== 4'h0) begin bad++; $display("FAIL rst_dbe: got %b want 0", DBe); end
    total++; if (W_RegWrite !== 1'b0) begin bad++; $display("FAIL rst_wrw: got %b want 0", W_RegWrite); end
    total++; if (W_WriteData !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %h want 0", W_WriteData); end
    RST = 1;
    @(posedge CLK); #1;
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", Stall); end
  endtask

  task automatic test_nonmem();
    issue("alu", 0,0,0,0,0,0, 1,0, 32'h12345678, 32'h0, 5'd7, 0, 32'h0, 0);
    total++; if (r_stalls !== 0) begin bad++; $display("FAIL alu_stalls: got %0d want 0", r_stalls); end
    total++; if (W_RegWrite !== 1'b1) begin bad++; $display("FAIL alu_wrw: got %b want 1", W_RegWrite); end
    total++; if (W_RegDst !== 5'd7) begin bad++; $display("FAIL alu_dst: got %0d want 7", W_RegDst); end
    total++; if (W_WriteData !== 32'h12345678) begin bad++; $display("FAIL alu_wdata: got %h want 12345678", W_WriteData); end
    // DReady while idle must be ignored.
    DReady = 1; DRData = 32'hFFFFFFFF;
    @(posedge CLK); #1;
    DReady = 0;
    total++; if (DReq !== 1'b0 || Stall !== 1'b0) begin bad++; $display("FAIL idle_dready: got DReq=%b Stall=%b want 0 0", DReq, Stall); end
  endtask

  task automatic test_loads();
    issue("lw", 1,0,0,0,0,0, 1,1, 32'h100, 32'h0, 5'd8, 2, 32'hDEADBEEF, 0);
    total++; if (r_stalls !== 4) begin bad++; $display("FAIL lw_stalls: got %0d want 4", r_stalls); end
    total++; if (r_addr !== 30'h40) begin bad++; $display("FAIL lw_daddr: got %h want 40", r_addr); end
    total++; if (r_be !== 4'hF) begin bad++; $display("FAIL lw_dbe: got %b want 1111", r_be); end
    total++; if (r_we !== 1'b0) begin bad++; $display("FAIL lw_dwe: got %b want 0", r_we); end
    total++; if (W_WriteData !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_wdata: got %h want deadbeef", W_WriteData); end
    total++; if (W_RegWrite !== 1'b1) begin bad++; $display("FAIL lw_wrw: got %b want 1", W_RegWrite); end

    issue("lb", 1,0,0,1,1,0, 1,1, 32'h103, 32'h0, 5'd9, 0, 32'h000000F0, 0);
    total++; if (r_stalls !== 2) begin bad++; $display("FAIL lb_stalls: got %0d want 2", r_stalls); end
    total++; if (r_be !== 4'b0001) begin bad++; $display("FAIL lb_dbe: got %b want 0001", r_be); end
    total++; if (W_WriteData !== 32'hFFFFFFF0) begin bad++; $display("FAIL lb_wdata: got %h want fffffff0", W_WriteData); end

    issue("lbu", 1,0,0,1,0,0, 1,1, 32'h103, 32'h0, 5'd9, 0, 32'h000000F0, 0);
    total++; if (W_WriteData !== 32'h000000F0) begin bad++; $display("FAIL lbu_wdata: got %h want 000000f0", W_WriteData); end

    issue("lh", 1,0,1,0,1,0, 1,1, 32'h102, 32'h0, 5'd10, 1, 32'h00008001, 0);
    total++; if (r_be !== 4'b0011) begin bad++; $display("FAIL lh_dbe: got %b want 0011", r_be); end
    total++; if (W_WriteData !== 32'hFFFF8001) begin bad++; $display("FAIL lh_wdata: got %h want ffff8001", W_WriteData); end

    issue("lhu", 1,0,1,0,0,0, 1,1, 32'h100, 32'h0, 5'd10, 0, 32'hABCD0000, 0);
    total++; if (W_WriteData !== 32'h0000ABCD) begin bad++; $display("FAIL lhu_wdata: got %h want 0000abcd", W_WriteData); end
  endtask

  task automatic test_stores();
    issue("sh", 0,1,1,0,0,0, 0,0, 32'h202, 32'h1234ABCD, 5'd0, 0, 32'h0, 0);
    total++; if (r_wdata !== 32'hABCDABCD) begin bad++; $display("FAIL sh_dwdata: got %h want abcdabcd", r_wdata); end
    total++; if (r_be !== 4'b0011) begin bad++; $display("FAIL sh_dbe: got %b want 0011", r_be); end
    total++; if (r_we !== 1'b1) begin bad++; $display("FAIL sh_dwe: got %b want 1", r_we); end
    total++; if (r_addr !== 30'h80) begin bad++; $display("FAIL sh_daddr: got %h want 80", r_addr); end

    issue("sb", 0,1,0,1,0,0, 0,0, 32'h201, 32'h00000055, 5'd0, 1, 32'h0, 0);
    total++; if (r_wdata !== 32'h55555555) begin bad++; $display("FAIL sb_dwdata: got %h want 55555555", r_wdata); end
    total++; if (r_be !== 4'b0100) begin bad++; $display("FAIL sb_dbe: got %b want 0100", r_be); end
    total++; if (r_stalls !== 3) begin bad++; $display("FAIL sb_stalls: got %0d want 3", r_stalls); end
  endtask

  task automatic test_misaligned();
    issue("lw_mis", 1,0,0,0,0,0, 1,1, 32'h102, 32'h0, 5'd11, 0, 32'h0, 0);
    total++; if (r_aerr !== 1'b1) begin bad++; $display("FAIL mis_aerr: got %b want 1", r_aerr); end
    total++; if (r_stalls !== 0 || r_req !== 1'b0 || DReq !== 1'b0) begin bad++; $display("FAIL mis_bus: got stalls=%0d req=%b want 0 0", r_stalls, r_req | DReq); end
    total++; if (W_RegWrite !== 1'b0) begin bad++; $display("FAIL mis_wrw: got %b want 0", W_RegWrite); end
    issue("lh_mis", 1,0,1,0,0,0, 1,1, 32'h101, 32'h0, 5'd11, 0, 32'h0, 0);
    total++; if (r_aerr !== 1'b1 || r_stalls !== 0) begin bad++; $display("FAIL lhmis: got aerr=%b stalls=%0d want 1 0", r_aerr, r_stalls); end
  endtask

  task automatic test_llsc();
    issue("ll", 1,0,0,0,0,1, 1,1, 32'h300, 32'h0, 5'd12, 0, 32'h11112222, 0);
    total++; if (W_WriteData !== 32'h11112222) begin bad++; $display("FAIL ll_wdata: got %h want 11112222", W_WriteData); end
    issue("sc_ok", 0,1,0,0,0,1, 1,0, 32'h300, 32'hCAFEF00D, 5'd12, 0, 32'h0, 0);
    total++; if (r_req !== 1'b1 || r_we !== 1'b1) begin bad++; $display("FAIL sc_ok_bus: got req=%b we=%b want 1 1", r_req, r_we); end
    total++; if (W_WriteData !== 32'h1 || W_RegWrite !== 1'b1) begin bad++; $display("FAIL sc_ok_rt: got %h rw=%b want 1 1", W_WriteData, W_RegWrite); end
    issue("sc_again", 0,1,0,0,0,1, 1,0, 32'h300, 32'hCAFEF00D, 5'd12, 0, 32'h0, 0);
    total++; if (r_req !== 1'b0 || r_stalls !== 0) begin bad++; $display("FAIL sc2_bus: got req=%b stalls=%0d want 0 0", r_req, r_stalls); end
    total++; if (W_WriteData !== 32'h0 || W_RegWrite !== 1'b1) begin bad++; $display("FAIL sc2_rt: got %h rw=%b want 0 1", W_WriteData, W_RegWrite); end
    // LL then LLClear then SC
    issue("ll2", 1,0,0,0,0,1, 1,1, 32'h300, 32'h0, 5'd12, 0, 32'h0, 0);
    LLClear = 1; @(posedge CLK); #1; LLClear = 0;
    issue("sc_clr", 0,1,0,0,0,1, 1,0, 32'h300, 32'h0, 5'd12, 0, 32'h0, 0);
    total++; if (W_WriteData !== 32'h0 || r_req !== 1'b0) begin bad++; $display("FAIL sc_clr: got rt=%h req=%b want 0 0", W_WriteData, r_req); end
    // LL then plain store to the linked word then SC
    issue("ll3", 1,0,0,0,0,1, 1,1, 32'h300, 32'h0, 5'd12, 0, 32'h0, 0);
    issue("sw", 0,1,0,0,0,0, 0,0, 32'h300, 32'h77, 5'd0, 0, 32'h0, 0);
    issue("sc_sw", 0,1,0,0,0,1, 1,0, 32'h300, 32'h0, 5'd12, 0, 32'h0, 0);
    total++; if (W_WriteData !== 32'h0 || r_req !== 1'b0) begin bad++; $display("FAIL sc_after_sw: got rt=%h req=%b want 0 0", W_WriteData, r_req); end
  endtask

  task automatic test_flush();
    issue("ll5", 1,0,0,0,0,1, 1,1, 32'h500, 32'h0, 5'd13, 0, 32'h0, 0);
    issue("ll6_flush", 1,0,0,0,0,1, 1,1, 32'h600, 32'h0, 5'd14, 1, 32'h0, 1);
    total++; if (r_req !== 1'b1 || r_stalls !== 3) begin bad++; $display("FAIL flush_bus: got req=%b stalls=%0d want 1 3", r_req, r_stalls); end
    total++; if (W_RegWrite !== 1'b0) begin bad++; $display("FAIL flush_wrw: got %b want 0", W_RegWrite); end
    issue("sc5", 0,1,0,0,0,1, 1,0, 32'h500, 32'h0, 5'd13, 0, 32'h0, 0);
    total++; if (W_WriteData !== 32'h1 || r_req !== 1'b1) begin bad++; $display("FAIL flush_link: got rt=%h req=%b want 1 1", W_WriteData, r_req); end
  endtask

  task automatic test_reset_mid_req();
    MemRead = 1; RegWrite = 1; MemtoReg = 1; ALUResult = 32'h700; RegDstOut = 5'd3;
    @(posedge CLK); #1;
    total++; if (DReq !== 1'b1) begin bad++; $display("FAIL rstreq_pre: got DReq=%b want 1", DReq); end
    #2; RST = 0; #1;
    $display("txn rst_mid_req: DReq=%b DAddr=%h W_RegDst=%0d", DReq, DAddr, W_RegDst);
    total++; if (DReq !== 1'b0 || DAddr !== 30'h0 || DBe !== 4'h0) begin bad++; $display("FAIL rstreq_bus: got DReq=%b DAddr=%h DBe=%b want 0 0 0", DReq, DAddr, DBe); end
    total++; if (W_RegDst !== 5'd0 || W_WriteData !== 32'h0 || W_RegWrite !== 1'b0) begin bad++; $display("FAIL rstreq_w: got dst=%0d wd=%h rw=%b want 0 0 0", W_RegDst, W_WriteData, W_RegWrite); end
    nop_inputs();
    @(posedge CLK); #1; RST = 1;
    @(posedge CLK); #1;
    total++; if (Stall !== 1'b0 || DReq !== 1'b0) begin bad++; $display("FAIL rstreq_after: got Stall=%b DReq=%b want 0 0", Stall, DReq); end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_loads();
    test_stores();
    test_misaligned();
    test_llsc();
    test_flush();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the MIPS III pipeline, sitting directly downstream of the EX/MEM pipeline register and feeding the writeback stage. It sequences a registered request/ready handshake to the data memory, formats byte/halfword/word loads and stores, and implements the LL/SC link bit. It produces the MEM-stage stall and the MEM/WB pipeline register outputs.

## Interface
- BIG_ENDIAN, 1, byte-lane ordering; 1 = address offset 0 on bits 31:24.
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC, RegWrite, MemtoReg  in  1 each  EX/MEM control.
- ALUResult  in  32  effective address or ALU result.
- ReadData2  in  32  store data (rt).
- RegDstOut  in  5  destination register.
- Flush  in  1  kill the instruction currently in MEM (exception from later logic).
- LLClear  in  1  clear link bit (ERET).
- Stall  out  1  MEM stall to EX/MEM and upstream stages.
- AddrErr  out  1  combinational misaligned-access flag, valid while a memory op is in MEM.
- DReq, DWe  out  1 each  data-bus request / write enable (registered).
- DAddr  out  30  word address (registered).
- DBe  out  4  byte enables (registered).
- DWData  out  32  write data (registered).
- DReady  in  1  bus completion, sampled only in REQ.
- DRData  in  32  read data, valid when DReady.
- W_RegWrite  out  1, W_RegDst  out  5, W_WriteData  out  32: MEM/WB register.

## Operation
- Mem op = MemRead | MemWrite. Misaligned: MemHalf with A[0]=1, or word (neither Half nor Byte) with A[1:0]≠0 → AddrErr=1, no bus access, no stall, W_RegWrite=0.
- SC (LLSC & MemWrite): succeeds iff LLBit=1 and LLAddr = A[31:2]. Fail → no bus access, no stall, writes 0 to rt. Success → normal store, writes 1 to rt. Any SC clears LLBit.
- LL (LLSC & MemRead): on completion sets LLBit=1, LLAddr=A[31:2]. Normal store completing to LLAddr clears LLBit. LLClear clears LLBit; LLClear with LL completion in the same cycle → LLBit=0.
- Stores: byte replicated to all four lanes, half replicated to both halves; DBe selects lanes per BIG_ENDIAN.
- Loads: lane extracted from DRData; MemSignExtend selects sign vs zero extension.
- FSM states IDLE, REQ, DONE:
  - IDLE: valid bus op (mem op, aligned, not failed SC, not Flush) → load DReq/DAddr/DBe/DWe/DWData, go REQ. Otherwise stay.
  - REQ: hold bus outputs stable; DReady=1 → capture DRData, drop DReq, go DONE.
  - DONE: unconditionally → IDLE.
- Stall = (IDLE & valid bus op) | REQ. Deasserted in DONE, non-memory cycles, misaligned, failed SC.
- W_WriteData = MemtoReg ? formatted load : SC ? {31'b0, success} : ALUResult.
- W_RegWrite loads RegWrite & ~Stall & ~Flush & ~AddrErr & ~abort; bubble (0) while Stall.
- Flush in REQ: set abort; transaction still completes on DReady (no cancellation); DONE writes W_RegWrite=0 and LL/link updates suppressed. Flush in DONE: same suppression.

## Timing
- Reset (async, RST=0): state=IDLE, DReq=DWe=0, DAddr=DBe=DWData=0, LLBit=0, LLAddr=0, abort=0, W_RegWrite=0, W_RegDst=0, W_WriteData=0.
- Non-memory instruction: one cycle in MEM, W_* valid next edge.
- Memory op, DReady=1 on first REQ cycle: Stall high 2 cycles (IDLE, REQ), DONE cycle advances; W_* updated at end of DONE; 3 cycles total.
- Each extra wait cycle in REQ adds one stall cycle.
- DReady outside REQ ignored.
- Reset during REQ drops DReq immediately; memory must tolerate an abandoned request.

## Structure
- Package mem_pkg: FSM state enum, lane-select/byte-enable and load-extension functions, ALIGN checks.
- One sub-module mem_align: combinational store-lane replication + DBe, load extraction + extension, parameterised by BIG_ENDIAN.

## Test plan
- LW A=0x100, DReady after 2 waits, DRData=0xDEADBEEF → Stall 4 cycles, DAddr=0x40, DBe=4'hF, W_WriteData=0xDEADBEEF, W_RegWrite=1.
- LB signed A=0x103, DRData=0x000000F0 (big-endian) → DBe=4'b0001, W_WriteData=0xFFFFFFF0; LBU → 0x000000F0.
- SH A=0x202, ReadData2=0x1234ABCD → DWData=0xABCDABCD, DBe=4'b0011, DWe=1.
- LW A=0x102 → AddrErr=1, DReq never asserts, Stall=0, W_RegWrite=0.
- LL A=0x300 then SC A=0x300 → bus write, rt=1; second SC → no bus, rt=0; LL, LLClear, SC → rt=0.
- Flush during REQ → bus completes on DReady, W_RegWrite=0, LLBit unchanged; RST low mid-REQ → DReq=0 and all outputs zero immediately.
